mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 191 +++++++++++++++++++
 tb/tb_mc_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode,
// condition check and the architectural NZCV flag register.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state;
  state_t     next;
  logic [3:0] flags_q;
  logic [3:0] cmd;
  logic [1:0] dec_ctl;
  logic       is_addsub;
  logic       cond_ok;
  logic       upd_flags;
  logic       pcw;
  logic       irw;
  logic       rw;
  logic       mw;
  logic       n;
  logic       z;
  logic       c;
  logic       v;

  assign cmd       = Funct[4:1];
  assign is_addsub = (cmd == 4'b0100) || (cmd == 4'b0010);
  assign {n, z, c, v} = flags_q;

  always_comb begin
    dec_ctl = 2'b00;
    unique case (cmd)
      4'b0100: dec_ctl = 2'b00;
      4'b0010: dec_ctl = 2'b01;
      4'b0000: dec_ctl = 2'b10;
      4'b1100: dec_ctl = 2'b11;
      default: dec_ctl = 2'b00;
    endcase
  end

  always_comb begin
    cond_ok = 1'b1;
    unique case (Cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = c & !z;
      4'b1001: cond_ok = !c | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    next       = FETCH;
    pcw        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    unique case (state)
      FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (cond_ok) begin
          unique case (Op)
            2'b01:   next = MEMADR;
            2'b00:   next = Funct[5] ? EXECUTEI : EXECUTER;
            2'b10:   next = BRANCH;
            default: next = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        next    = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        pcw       = (Rd == 4'd15);
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      EXECUTER: begin
        ALUControl = dec_ctl;
        next       = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dec_ctl;
        next       = ALUWB;
      end
      ALUWB: begin
        rw  = 1'b1;
        pcw = (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  assign upd_flags = ((state == EXECUTER) || (state == EXECUTEI)) && Funct[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state <= next;
      if (upd_flags) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (is_addsub) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // enables stay low for the whole time reset is held, not only after the edge
  assign PCWrite  = pcw & reset;
  assign IRWrite  = irw & reset;
  assign RegWrite = rw & reset;
  assign MemWrite = mw & reset;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign Flags  = flags_q;
  assign State  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller: per-cycle table of
// inputs and expected outputs plus instruction cycle-count runs.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] Flags;
  logic [3:0] State;

  mc_controller dut (
    .clk(clk),
    .reset(reset),
    .Cond(Cond),
    .Op(Op),
    .Funct(Funct),
    .Rd(Rd),
    .ALUFlags(ALUFlags),
    .PCWrite(PCWrite),
    .IRWrite(IRWrite),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite),
    .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc),
    .RegSrc(RegSrc),
    .ALUControl(ALUControl),
    .Flags(Flags),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluf;
    logic [3:0] st;
    logic [3:0] en;
    logic [1:0] ctl;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   tests;
  int   fails;

  // datapath selects expected in each state: {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
  function automatic logic [6:0] dp_of(input logic [3:0] st);
    case (st)
      4'd0, 4'd1: return 7'b0_10_01_10;
      4'd2:       return 7'b0_00_00_01;
      4'd3, 4'd5: return 7'b1_00_00_00;
      4'd4:       return 7'b0_01_00_00;
      4'd7:       return 7'b0_00_00_01;
      4'd9:       return 7'b0_10_10_01;
      default:    return 7'b0_00_00_00;
    endcase
  endfunction

  task automatic set_in(input logic r, input logic [3:0] cd,
                        input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] d, input logic [3:0] af);
    cur.rst   = r;
    cur.cond  = cd;
    cur.op    = o;
    cur.funct = f;
    cur.rd    = d;
    cur.aluf  = af;
  endtask

  task automatic add(input logic [3:0] st, input logic [3:0] en,
                     input logic [1:0] ctl, input logic [3:0] fl);
    vec_t v;
    v     = cur;
    v.st  = st;
    v.en  = en;
    v.ctl = ctl;
    v.fl  = fl;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset    = v.rst;
    Cond     = v.cond;
    Op       = v.op;
    Funct    = v.funct;
    Rd       = v.rd;
    ALUFlags = v.aluf;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (State != 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (State != 4'd0) begin
      tests++;
      fails++;
      $display("FAIL wait_fetch: State=%0d required 0 within 20 cycles", State);
    end
  endtask

  task automatic run_instr(input string name, input logic [3:0] cd,
                           input logic [1:0] o, input logic [5:0] f,
                           input int exp_cyc, input int exp_mw);
    int cyc;
    int mw;
    wait_fetch();
    reset    = 1'b1;
    Cond     = cd;
    Op       = o;
    Funct    = f;
    Rd       = 4'd0;
    ALUFlags = 4'b0000;
    cyc      = 0;
    mw       = 0;
    do begin
      #1;
      if (MemWrite) mw++;
      @(negedge clk);
      cyc++;
    end while (State != 4'd0 && cyc < 20);
    tests++;
    if (cyc != exp_cyc) begin
      fails++;
      $display("FAIL %s cycles: got %0d required %0d", name, cyc, exp_cyc);
    end
    tests++;
    if (mw != exp_mw) begin
      fails++;
      $display("FAIL %s memwrite cycles: got %0d required %0d", name, mw, exp_mw);
    end
  endtask

  initial begin
    logic [20:0] got;
    logic [20:0] exp;
    tests = 0;
    fails = 0;

    set_in(0, 4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
    add(4'd0, 4'b0000, 2'b00, 4'b0000);
    // ADDS immediate
    set_in(1, 4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
    add(4'd0, 4'b1100, 2'b00, 4'b0000);
    add(4'd1, 4'b0000, 2'b00, 4'b0000);
    add(4'd7, 4'b0000, 2'b00, 4'b0000);
    add(4'd8, 4'b0010, 2'b00, 4'b0110);
    // LDR into r15
    set_in(1, 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b1111);
    add(4'd0, 4'b1100, 2'b00, 4'b0110);
    add(4'd1, 4'b0000, 2'b00, 4'b0110);
    add(4'd2, 4'b0000, 2'b00, 4'b0110);
    add(4'd3, 4'b0000, 2'b00, 4'b0110);
    add(4'd4, 4'b1010, 2'b00, 4'b0110);
    // STR
    set_in(1, 4'b1110, 2'b01, 6'b011000, 4'd2, 4'b1111);
    add(4'd0, 4'b1100, 2'b00, 4'b0110);
    add(4'd1, 4'b0000, 2'b00, 4'b0110);
    add(4'd2, 4'b0000, 2'b00, 4'b0110);
    add(4'd5, 4'b0001, 2'b00, 4'b0110);
    // SUBS register -> flags 0100
    set_in(1, 4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100);
    add(4'd0, 4'b1100, 2'b00, 4'b0110);
    add(4'd1, 4'b0000, 2'b00, 4'b0110);
    add(4'd6, 4'b0000, 2'b01, 4'b0110);
    add(4'd8, 4'b0010, 2'b00, 4'b0100);
    // BNE with Z=1 fails
    set_in(1, 4'b0001, 2'b10, 6'b100000, 4'd0, 4'b1111);
    add(4'd0, 4'b1100, 2'b00, 4'b0100);
    add(4'd1, 4'b0000, 2'b00, 4'b0100);
    // BEQ with Z=1 taken
    set_in(1, 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b1111);
    add(4'd0, 4'b1100, 2'b00, 4'b0100);
    add(4'd1, 4'b0000, 2'b00, 4'b0100);
    add(4'd9, 4'b1000, 2'b00, 4'b0100);
    // ADDS imm clearing flags
    set_in(1, 4'b1110, 2'b00, 6'b101001, 4'd4, 4'b0000);
    add(4'd0, 4'b1100, 2'b00, 4'b0100);
    add(4'd1, 4'b0000, 2'b00, 4'b0100);
    add(4'd7, 4'b0000, 2'b00, 4'b0100);
    add(4'd8, 4'b0010, 2'b00, 4'b0000);
    // ANDS: C,V held
    set_in(1, 4'b1110, 2'b00, 6'b000001, 4'd5, 4'b1011);
    add(4'd0, 4'b1100, 2'b00, 4'b0000);
    add(4'd1, 4'b0000, 2'b00, 4'b0000);
    add(4'd6, 4'b0000, 2'b10, 4'b0000);
    add(4'd8, 4'b0010, 2'b00, 4'b1000);
    // ORR without S into r15
    set_in(1, 4'b1110, 2'b00, 6'b011000, 4'd15, 4'b0101);
    add(4'd0, 4'b1100, 2'b00, 4'b1000);
    add(4'd1, 4'b0000, 2'b00, 4'b1000);
    add(4'd6, 4'b0000, 2'b11, 4'b1000);
    add(4'd8, 4'b1010, 2'b00, 4'b1000);
    // unknown cmd with S: ADD control, only N,Z load
    set_in(1, 4'b1110, 2'b00, 6'b110111, 4'd6, 4'b1111);
    add(4'd0, 4'b1100, 2'b00, 4'b1000);
    add(4'd1, 4'b0000, 2'b00, 4'b1000);
    add(4'd7, 4'b0000, 2'b00, 4'b1000);
    add(4'd8, 4'b0010, 2'b00, 4'b1100);
    // Op=11
    set_in(1, 4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
    add(4'd0, 4'b1100, 2'b00, 4'b1100);
    add(4'd1, 4'b0000, 2'b00, 4'b1100);
    // GE false with N=1,V=0
    set_in(1, 4'b1010, 2'b10, 6'b100000, 4'd0, 4'b0000);
    add(4'd0, 4'b1100, 2'b00, 4'b1100);
    add(4'd1, 4'b0000, 2'b00, 4'b1100);
    // LS true with Z=1
    set_in(1, 4'b1001, 2'b10, 6'b100000, 4'd0, 4'b0000);
    add(4'd0, 4'b1100, 2'b00, 4'b1100);
    add(4'd1, 4'b0000, 2'b00, 4'b1100);
    add(4'd9, 4'b1000, 2'b00, 4'b1100);
    // LDR aborted by reset in MEMREAD
    set_in(1, 4'b1110, 2'b01, 6'b011001, 4'd1, 4'b0000);
    add(4'd0, 4'b1100, 2'b00, 4'b1100);
    add(4'd1, 4'b0000, 2'b00, 4'b1100);
    add(4'd2, 4'b0000, 2'b00, 4'b1100);
    cur.rst = 1'b0;
    add(4'd3, 4'b0000, 2'b00, 4'b1100);
    add(4'd0, 4'b0000, 2'b00, 4'b0000);
    cur.rst = 1'b1;
    add(4'd0, 4'b1100, 2'b00, 4'b0000);
    add(4'd1, 4'b0000, 2'b00, 4'b0000);

    drive(vecs[0]);
    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      got = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Flags};
      exp = {vecs[i].st, vecs[i].en, dp_of(vecs[i].st), vecs[i].ctl, vecs[i].fl};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL vec%0d {st,en,adr,res,a,b,ctl,fl}: got %b required %b",
                 i, got, exp);
      end
      @(negedge clk);
    end

    run_instr("ldr", 4'b1110, 2'b01, 6'b011001, 5, 0);
    run_instr("str", 4'b1110, 2'b01, 6'b011000, 4, 1);
    run_instr("dp", 4'b1110, 2'b00, 6'b001000, 4, 0);
    run_instr("b", 4'b1110, 2'b10, 6'b100000, 3, 0);
    run_instr("condfail", 4'b0000, 2'b10, 6'b100000, 2, 0);
    run_instr("op11", 4'b1110, 2'b11, 6'b000000, 2, 0);

    for (int o = 0; o < 4; o++) begin
      logic [1:0] ov;
      logic [1:0] rs;
      ov = 2'(o);
      Op = ov;
      rs = {ov == 2'b01, ov == 2'b10};
      #1;
      tests++;
      if (ImmSrc !== ov || RegSrc !== rs) begin
        fails++;
        $display("FAIL srcsel op=%0d: ImmSrc=%b RegSrc=%b required %b %b",
                 o, ImmSrc, RegSrc, ov, rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
